// File: rtl/mem_arb_pkg.sv
// Shared types and block geometry for the memory fill arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {QUIET, IDLE, FILL, DONE} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  localparam int BLK_OFF_BITS  = 4;
  localparam int WORD_IDX_BITS = 3;

endpackage

// File: rtl/blk_word_cnt.sv
// Word index counter within a cache block: clear has priority over increment.
module blk_word_cnt
  import mem_arb_pkg::*;
#(
  parameter int WORDS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     inc,
  output logic [WORD_IDX_BITS-1:0] cnt,
  output logic                     last
);

  localparam logic [WORD_IDX_BITS-1:0] LAST_IDX = WORD_IDX_BITS'(WORDS - 1);

  logic [WORD_IDX_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) cnt_d = '0;
    else if (inc) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == LAST_IDX);

endmodule

// File: rtl/mem_fill_arbiter.sv
// Sequences main memory between I/D block fills and D write-through stores; freezes the pipeline during fills.
// Define MEM_ARB_PERF_EN to add saturating fill and stall counters (perf_ifill, perf_dfill, perf_stall).
module mem_fill_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int WORDS_PER_BLK = 8,
  parameter int MEM_LAT       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     icache_miss,
  input  logic [ADDR_W-1:0]        icache_miss_addr,
  input  logic                     dcache_miss,
  input  logic [ADDR_W-1:0]        dcache_miss_addr,
  input  logic                     dcache_wr,
  input  logic [ADDR_W-1:0]        dcache_wr_addr,
  input  logic [DATA_W-1:0]        dcache_wr_data,
  output logic                     mem_enable,
  output logic                     mem_wr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_data_valid,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [DATA_W-1:0]        fill_data,
  output logic [WORD_IDX_BITS-1:0] fill_word,
  output logic                     icache_fill_we,
  output logic                     dcache_fill_we,
  output logic                     icache_fill_done,
  output logic                     dcache_fill_done,
  output logic                     pipe_wen
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]              perf_ifill,
  output logic [15:0]              perf_dfill,
  output logic [15:0]              perf_stall
`endif
);

  localparam int                QCNT_W     = $clog2(MEM_LAT + 1);
  localparam logic [QCNT_W-1:0] QUIET_LAST = QCNT_W'(MEM_LAT - 1);
  localparam logic [ADDR_W-1:0] BLK_MASK   = ADDR_W'((1 << BLK_OFF_BITS) - 1);

  arb_state_t               state_q, state_d;
  owner_t                   owner_q, owner_d;
  logic [ADDR_W-1:0]        base_q, base_d;
  logic [QCNT_W-1:0]        quiet_q, quiet_d;
  logic                     issue_done_q, issue_done_d;
  logic [DATA_W-1:0]        fill_data_q, fill_data_d;
  logic [WORD_IDX_BITS-1:0] fill_word_q, fill_word_d;
  logic                     fill_we_q, fill_we_d;

  logic                     issue_clr, issue_inc, issue_last;
  logic                     recv_clr, recv_inc, recv_last;
  logic [WORD_IDX_BITS-1:0] issue_cnt, recv_cnt;

  blk_word_cnt #(.WORDS(WORDS_PER_BLK)) u_issue_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (issue_clr),
    .inc  (issue_inc),
    .cnt  (issue_cnt),
    .last (issue_last)
  );

  blk_word_cnt #(.WORDS(WORDS_PER_BLK)) u_recv_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (recv_clr),
    .inc  (recv_inc),
    .cnt  (recv_cnt),
    .last (recv_last)
  );

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    base_d           = base_q;
    quiet_d          = quiet_q;
    issue_done_d     = issue_done_q;
    fill_data_d      = fill_data_q;
    fill_word_d      = fill_word_q;
    fill_we_d        = 1'b0;
    issue_clr        = 1'b0;
    issue_inc        = 1'b0;
    recv_clr         = 1'b0;
    recv_inc         = 1'b0;
    mem_enable       = 1'b0;
    mem_wr           = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;
    icache_fill_done = 1'b0;
    dcache_fill_done = 1'b0;
    pipe_wen         = 1'b0;
    case (state_q)
      // Returns still in flight from before reset drain here unseen.
      QUIET: begin
        quiet_d = quiet_q + 1'b1;
        if (quiet_q == QUIET_LAST) begin
          quiet_d = '0;
          state_d = IDLE;
        end
      end
      IDLE: begin
        pipe_wen = ~(icache_miss | dcache_miss);
        if (dcache_wr) begin
          mem_enable = 1'b1;
          mem_wr     = 1'b1;
          mem_addr   = dcache_wr_addr;
          mem_wdata  = dcache_wr_data;
        end else if (dcache_miss) begin
          owner_d = OWN_D;
          base_d  = dcache_miss_addr & ~BLK_MASK;
          state_d = FILL;
        end else if (icache_miss) begin
          owner_d = OWN_I;
          base_d  = icache_miss_addr & ~BLK_MASK;
          state_d = FILL;
        end
      end
      FILL: begin
        if (!issue_done_q) begin
          mem_enable = 1'b1;
          mem_addr   = base_q + ADDR_W'({issue_cnt, 1'b0});
          if (issue_last) issue_done_d = 1'b1;
          else            issue_inc    = 1'b1;
        end
        if (mem_data_valid) begin
          fill_data_d = mem_rdata;
          fill_word_d = recv_cnt;
          fill_we_d   = 1'b1;
          if (recv_last) begin
            state_d      = DONE;
            issue_clr    = 1'b1;
            recv_clr     = 1'b1;
            issue_done_d = 1'b0;
          end else begin
            recv_inc = 1'b1;
          end
        end
      end
      DONE: begin
        icache_fill_done = (owner_q == OWN_I);
        dcache_fill_done = (owner_q == OWN_D);
        state_d          = IDLE;
      end
      default: state_d = QUIET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= QUIET;
      owner_q      <= OWN_I;
      base_q       <= '0;
      quiet_q      <= '0;
      issue_done_q <= 1'b0;
      fill_data_q  <= '0;
      fill_word_q  <= '0;
      fill_we_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      base_q       <= base_d;
      quiet_q      <= quiet_d;
      issue_done_q <= issue_done_d;
      fill_data_q  <= fill_data_d;
      fill_word_q  <= fill_word_d;
      fill_we_q    <= fill_we_d;
    end
  end

  assign fill_data      = fill_data_q;
  assign fill_word      = fill_word_q;
  assign icache_fill_we = fill_we_q & (owner_q == OWN_I);
  assign dcache_fill_we = fill_we_q & (owner_q == OWN_D);

`ifdef MEM_ARB_PERF_EN
  logic [15:0] perf_ifill_q, perf_ifill_d;
  logic [15:0] perf_dfill_q, perf_dfill_d;
  logic [15:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_ifill_d = perf_ifill_q;
    perf_dfill_d = perf_dfill_q;
    perf_stall_d = perf_stall_q;
    if (icache_fill_done && (perf_ifill_q != 16'hFFFF)) perf_ifill_d = perf_ifill_q + 1'b1;
    if (dcache_fill_done && (perf_dfill_q != 16'hFFFF)) perf_dfill_d = perf_dfill_q + 1'b1;
    if (!pipe_wen && (perf_stall_q != 16'hFFFF))        perf_stall_d = perf_stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ifill_q <= '0;
      perf_dfill_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_ifill_q <= perf_ifill_d;
      perf_dfill_q <= perf_dfill_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_ifill = perf_ifill_q;
  assign perf_dfill = perf_dfill_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule
